// File: rtl/slow_countdown.sv
// Prescaled 16-bit countdown timer with IDLE/RUN/DONE control.
// Q decrements once every 2^PRESCALE_BITS non-held RUN cycles.
module slow_countdown #(
    parameter int unsigned PRESCALE_BITS = 24
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        LOAD,
    input  logic [15:0] D,
    input  logic        START,
    input  logic        HOLD,
    output logic [15:0] Q,
    output logic        BUSY,
    output logic        EXPIRED,
    output logic        DONE_P
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              q_q, q_d;
    logic [PRESCALE_BITS-1:0] pre_q, pre_d;
    logic                     done_p_d;
    logic                     tick;

    assign tick = (state_q == RUN) && !HOLD && (pre_q == '1);

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        pre_d    = pre_q;
        done_p_d = 1'b0;
        case (state_q)
            IDLE: begin
                // LOAD has priority; START with a zero count is ignored.
                if (LOAD) begin
                    q_d   = D;
                    pre_d = '0;
                end else if (START && (q_q != '0)) begin
                    state_d = RUN;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (LOAD) begin
                    q_d     = D;
                    pre_d   = '0;
                    state_d = IDLE;
                end else if (!HOLD) begin
                    pre_d = pre_q + PRESCALE_BITS'(1);
                    if (tick) begin
                        if (q_q > 16'd1) begin
                            q_d = q_q - 16'd1;
                        end else begin
                            q_d      = '0;
                            state_d  = DONE;
                            done_p_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (LOAD) begin
                    q_d     = D;
                    pre_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            q_q     <= '0;
            pre_q   <= '0;
            BUSY    <= 1'b0;
            EXPIRED <= 1'b0;
            DONE_P  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pre_q   <= pre_d;
            BUSY    <= (state_d == RUN);
            EXPIRED <= (state_d == DONE);
            DONE_P  <= done_p_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_slow_countdown.sv
// Scoreboard bench for slow_countdown: a cycle-level reference model pushes
// expected outputs; an independent monitor pops and compares after each edge.
module tb_slow_countdown;

    localparam int PB   = 2;
    localparam int TICK = 1 << PB;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        LOAD = 1'b0;
    logic        START = 1'b0;
    logic        HOLD = 1'b0;
    logic [15:0] D = '0;
    logic [15:0] Q;
    logic        BUSY, EXPIRED, DONE_P;

    typedef struct packed {
        logic [15:0] q;
        logic        busy;
        logic        expired;
        logic        done_p;
    } obs_t;

    obs_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   pops   = 0;

    // Reference model: count value, running flag, expired flag, cycles to next tick.
    int m_q    = 0;
    bit m_run  = 0;
    bit m_exp  = 0;
    int m_left = TICK;
    bit m_dp   = 0;

    slow_countdown #(.PRESCALE_BITS(PB)) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .LOAD    (LOAD),
        .D       (D),
        .START   (START),
        .HOLD    (HOLD),
        .Q       (Q),
        .BUSY    (BUSY),
        .EXPIRED (EXPIRED),
        .DONE_P  (DONE_P)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t model_obs();
        obs_t e;
        e.q       = 16'(m_q);
        e.busy    = m_run;
        e.expired = m_exp;
        e.done_p  = m_dp;
        return e;
    endfunction

    function automatic obs_t dut_obs();
        obs_t a;
        a.q       = Q;
        a.busy    = BUSY;
        a.expired = EXPIRED;
        a.done_p  = DONE_P;
        return a;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got Q=%0d BUSY=%b EXPIRED=%b DONE_P=%b, expected Q=%0d BUSY=%b EXPIRED=%b DONE_P=%b",
                     name, $time, act.q, act.busy, act.expired, act.done_p,
                     exp.q, exp.busy, exp.expired, exp.done_p);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_run = 0; m_exp = 0; m_left = TICK; m_dp = 0;
    endtask

    task automatic model_step(input bit clr, input bit load, input bit start,
                              input bit hold, input int d);
        m_dp = 0;
        if (clr) begin
            model_reset();
        end else if (load) begin
            m_q = d; m_run = 0; m_exp = 0;
        end else if (m_run) begin
            if (!hold) begin
                m_left--;
                if (m_left == 0) begin
                    m_left = TICK;
                    if (m_q == 1) begin
                        m_q = 0; m_run = 0; m_exp = 1; m_dp = 1;
                    end else begin
                        m_q--;
                    end
                end
            end
        end else if (!m_exp && start && m_q != 0) begin
            m_run = 1; m_left = TICK;
        end
    endtask

    // One clock cycle of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic cyc(input bit clr, input bit load, input bit start,
                       input bit hold, input logic [15:0] d);
        @(negedge CLK);
        CLR = clr; LOAD = load; START = start; HOLD = hold; D = d;
        model_step(clr, load, start, hold, int'(d));
        expq.push_back(model_obs());
        pushes++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                pops++;
                compare("cycle", dut_obs(), e);
            end
        end
    end

    initial begin : stimulus
        obs_t rst_exp;
        rst_exp = '0;

        // Reset state, and START from Q==0 ignored.
        cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 0, 1, 0, 16'h9);
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 0, 1, 0, 16'h0);
        // LOAD with START in the same cycle: load only.
        cyc(0, 1, 1, 0, 16'd7);
        idle(2);

        // Basic countdown from 3.
        cyc(1, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 16'd3);
        cyc(0, 0, 1, 0, 16'h0);
        idle(16);

        // Countdown with a 10-cycle hold after the first decrement.
        cyc(0, 1, 0, 0, 16'd3);
        cyc(0, 0, 1, 0, 16'h0);
        idle(4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 16'h0);
        idle(12);

        // In DONE: reload 1, start, expire again.
        cyc(0, 1, 0, 0, 16'd1);
        cyc(0, 0, 1, 0, 16'h0);
        idle(6);

        // Abort by LOAD at Q==2.
        cyc(0, 1, 0, 0, 16'd3);
        cyc(0, 0, 1, 0, 16'h0);
        idle(4);
        cyc(0, 1, 0, 0, 16'd5);
        idle(3);

        // Asynchronous CLR between edges at Q==2.
        cyc(0, 1, 0, 0, 16'd3);
        cyc(0, 0, 1, 0, 16'h0);
        idle(5);
        @(posedge CLK);
        #3;
        CLR = 1'b1;
        model_reset();
        #1;
        compare("async_clr", dut_obs(), rst_exp);
        cyc(1, 0, 1, 0, 16'h4);
        cyc(0, 0, 0, 0, 16'h0);
        idle(12);

        // Full-scale load: first decrements without wrap.
        cyc(0, 1, 0, 0, 16'hFFFF);
        cyc(0, 0, 1, 0, 16'h0);
        idle(3 * TICK + 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          c, l, s, h;
            logic [15:0] dv;
            c  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 3) == 0);
            dv = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 6));
            cyc(c, l, s, h, dv);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (expq.size() != 0 || pops != pushes) begin
            errors++;
            $display("FAIL drain: %0d expectations left, %0d popped of %0d pushed",
                     expq.size(), pops, pushes);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slow_countdown.md
SLOW_COUNTDOWN -- requirements
Module: slow_countdown

Interface
REQ-001 PRESCALE_BITS, default 24, prescaler width; one tick every 2^PRESCALE_BITS counting cycles.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 CLR  input  1  reset, asynchronous and active-high.
REQ-004 LOAD  input  1  load D into Q and return to IDLE; level sampled each edge.
REQ-005 D  input  16  countdown start value.
REQ-006 START  input  1  begin counting from IDLE; level sampled each edge.
REQ-007 HOLD  input  1  while high in RUN, freeze prescaler and Q.
REQ-008 Q  output  16  current count, registered.
REQ-009 BUSY  output  1  high exactly while state is RUN.
REQ-010 EXPIRED  output  1  high exactly while state is DONE.
REQ-011 DONE_P  output  1  one-cycle pulse on the RUN->DONE transition.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; all outputs registered, no combinational input-to-output path.
REQ-013 Prescaler (PRESCALE_BITS wide) SHALL increment only when state is RUN and HOLD is low; it SHALL wrap from all-ones to zero.
REQ-014 Tick SHALL be asserted internally on a counting cycle in which the prescaler equals all-ones.
REQ-015 Entering RUN, and any LOAD, SHALL clear the prescaler to zero.
REQ-016 IDLE: LOAD=1 -> Q<=D, stay IDLE; LOAD=0, START=1, Q!=0 -> RUN; START with Q==0 SHALL be ignored.
REQ-017 IDLE with LOAD and START both high SHALL load D, stay IDLE, and ignore START.
REQ-018 RUN: LOAD=1 -> Q<=D, go IDLE (abort), no DONE_P, regardless of tick or HOLD.
REQ-019 RUN: tick with Q>1 -> Q<=Q-1, stay RUN.
REQ-020 RUN: tick with Q==1 -> Q<=0, go DONE, DONE_P=1 for that single following cycle.
REQ-021 RUN: HOLD=1 -> Q, prescaler, and state unchanged; START ignored.
REQ-022 DONE: Q held at 0, EXPIRED=1; START ignored; LOAD -> Q<=D, go IDLE.
REQ-023 Q SHALL never underflow; decrement from 0 SHALL be impossible.
REQ-024 First decrement SHALL occur 2^PRESCALE_BITS non-held cycles after the edge entering RUN; subsequent decrements every 2^PRESCALE_BITS non-held cycles.
REQ-025 D=16'hFFFF SHALL be accepted and count down fully without wrap.
REQ-026 DONE_P SHALL be low in every cycle other than the first DONE cycle.

Reset
REQ-027 CLR high SHALL immediately (without a clock edge) force state IDLE, Q=0, prescaler=0, BUSY=0, EXPIRED=0, DONE_P=0.
REQ-028 CLR asserted mid-RUN SHALL abort the count with no DONE_P.
REQ-029 While CLR high, all inputs SHALL be ignored; first sampled edge after release SHALL behave as IDLE.

Verification (PRESCALE_BITS=2, 4 cycles per tick)
REQ-030 CLR pulse, LOAD D=3, then START one cycle -> BUSY=1; Q=2,1,0 at 4,8,12 cycles after RUN entry; DONE_P high one cycle with Q=0; EXPIRED stays 1.
REQ-031 D=3 run, HOLD high 10 cycles after first decrement -> Q stays 2 throughout hold; Q=0 and DONE_P arrive 10 cycles later than REQ-030.
REQ-032 LOAD D=5 during RUN at Q=2 -> next cycle Q=5, BUSY=0, EXPIRED=0, DONE_P never asserted.
REQ-033 From reset (Q=0) START high -> state stays IDLE, BUSY=0, Q=0; LOAD D=7 with START same cycle -> Q=7, BUSY=0.
REQ-034 CLR asserted between clock edges mid-RUN at Q=2 -> Q=0, BUSY=0 before next edge; no DONE_P after release.
REQ-035 In DONE, LOAD D=1 then START -> one tick later Q=0, DONE_P pulses again, EXPIRED=1.
